// File: rtl/tns_decoder_27_pkg.sv
// rtl/tns_decoder_27_pkg.sv - shared widths, TNS group weights and FSM encodings
package tns_decoder_27_pkg;

    localparam int BLEN09     = 18;
    localparam int DW         = BLEN09;
    localparam int CW         = 27;
    localparam int TNS_GROUPS = 9;

    typedef logic [DW:0] term_t;

    // Each group carries one redundant base-4 digit: A = 2*base, B = C = base.
    localparam term_t TNS09_A = term_t'(131072);
    localparam term_t TNS09_B = term_t'(65536);
    localparam term_t TNS09_C = term_t'(65536);
    localparam term_t TNS08_A = term_t'(32768);
    localparam term_t TNS08_B = term_t'(16384);
    localparam term_t TNS08_C = term_t'(16384);
    localparam term_t TNS07_A = term_t'(8192);
    localparam term_t TNS07_B = term_t'(4096);
    localparam term_t TNS07_C = term_t'(4096);
    localparam term_t TNS06_A = term_t'(2048);
    localparam term_t TNS06_B = term_t'(1024);
    localparam term_t TNS06_C = term_t'(1024);
    localparam term_t TNS05_A = term_t'(512);
    localparam term_t TNS05_B = term_t'(256);
    localparam term_t TNS05_C = term_t'(256);
    localparam term_t TNS04_A = term_t'(128);
    localparam term_t TNS04_B = term_t'(64);
    localparam term_t TNS04_C = term_t'(64);
    localparam term_t TNS03_A = term_t'(32);
    localparam term_t TNS03_B = term_t'(16);
    localparam term_t TNS03_C = term_t'(16);
    localparam term_t TNS02_A = term_t'(8);
    localparam term_t TNS02_B = term_t'(4);
    localparam term_t TNS02_C = term_t'(4);
    localparam term_t TNS01_A = term_t'(2);
    localparam term_t TNS01_B = term_t'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/tns_decoder_27_group_weight.sv
// rtl/tns_decoder_27_group_weight.sv - weighted term of one 3-bit codeword group
module tns_group_weight
    import tns_decoder_27_pkg::*;
(
    input  logic [3:0]  index,
    input  logic [2:0]  bits,
    output logic [DW:0] term
);

    term_t wa;
    term_t wb;
    term_t wc;

    // index 0 is group 1 (least significant), index 8 is group 9
    always_comb begin
        wa = '0;
        wb = '0;
        wc = '0;
        case (index)
            4'd8: begin wa = TNS09_A; wb = TNS09_B; wc = TNS09_C; end
            4'd7: begin wa = TNS08_A; wb = TNS08_B; wc = TNS08_C; end
            4'd6: begin wa = TNS07_A; wb = TNS07_B; wc = TNS07_C; end
            4'd5: begin wa = TNS06_A; wb = TNS06_B; wc = TNS06_C; end
            4'd4: begin wa = TNS05_A; wb = TNS05_B; wc = TNS05_C; end
            4'd3: begin wa = TNS04_A; wb = TNS04_B; wc = TNS04_C; end
            4'd2: begin wa = TNS03_A; wb = TNS03_B; wc = TNS03_C; end
            4'd1: begin wa = TNS02_A; wb = TNS02_B; wc = TNS02_C; end
            4'd0: begin wa = TNS01_A; wb = TNS01_B; wc = term_t'(1); end
            default: begin wa = '0; wb = '0; wc = '0; end
        endcase
    end

    assign term = ({(DW+1){bits[2]}} & wa)
                + ({(DW+1){bits[1]}} & wb)
                + ({(DW+1){bits[0]}} & wc);

endmodule

// File: rtl/tns_decoder_27.sv
// rtl/tns_decoder_27.sv - iterative 27-bit TNS codeword decoder, one group per cycle
module tns_decoder_27
    import tns_decoder_27_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    input  logic [CW-1:0] codein,
    input  logic          code_valid,
    output logic          code_ready,
    output logic [DW-1:0] dataout,
    output logic          data_valid,
    input  logic          data_ready,
    output logic          code_err
);

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] code_q;
    logic [DW-1:0] acc;
    logic          ovf;
    logic [3:0]    grp;
    logic [DW:0]   term;
    logic [DW:0]   acc_sum;

    // code_q shifts left each RUN cycle, so its top group is always the one for grp
    tns_group_weight u_weight (
        .index (grp),
        .bits  (code_q[CW-1:CW-3]),
        .term  (term)
    );

    assign acc_sum = {1'b0, acc} + term;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (code_valid) state_nx = RUN;
            RUN:     if (grp == 4'd0) state_nx = DONE;
            DONE:    if (data_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            code_q <= '0;
            acc    <= '0;
            ovf    <= 1'b0;
            grp    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (code_valid) begin
                        code_q <= codein;
                        acc    <= '0;
                        ovf    <= 1'b0;
                        grp    <= 4'(TNS_GROUPS - 1);
                    end
                end
                RUN: begin
                    acc    <= acc_sum[DW-1:0];
                    ovf    <= ovf | acc_sum[DW];
                    code_q <= {code_q[CW-4:0], 3'b000};
                    if (grp != 4'd0) grp <= grp - 4'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        code_ready = (state == IDLE);
        data_valid = (state == DONE);
        dataout    = (state == DONE) ? acc : '0;
        code_err   = (state == DONE) & ovf;
    end

endmodule

// File: tb/tb_tns_decoder_27.sv
// tb/tb_tns_decoder_27.sv - self-checking bench for tns_decoder_27
module tb_tns_decoder_27;

    localparam int  DWB  = 18;
    localparam longint FULL = 64'd1 << DWB;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [26:0]     codein = '0;
    logic            code_valid = 1'b0;
    logic            code_ready;
    logic [DWB-1:0]  dataout;
    logic            data_valid;
    logic            data_ready = 1'b1;
    logic            code_err;

    int n_asserts = 0;
    int n_fail    = 0;

    tns_decoder_27 dut (
        .clock      (clock),
        .reset      (reset),
        .codein     (codein),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .dataout    (dataout),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .code_err   (code_err)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Group g (1..9) holds one digit of base 4**(g-1); bit weights are 2, 1, 1 times that base.
    function automatic longint model_sum(input logic [26:0] cw);
        longint s    = 0;
        longint base = 1;
        for (int g = 0; g < 9; g++) begin
            s    += base * (2 * longint'(cw[3*g+2]) + longint'(cw[3*g+1]) + longint'(cw[3*g]));
            base *= 4;
        end
        return s;
    endfunction

    // Encoder model: base-4 digits with a random choice among redundant bit patterns.
    function automatic logic [26:0] encode(input int unsigned v);
        logic [26:0] cw = '0;
        logic [2:0]  b;
        int unsigned d;
        for (int k = 0; k < 9; k++) begin
            d = (v >> (2 * k)) & 3;
            case (d)
                0:       b = 3'b000;
                1:       b = ($urandom_range(0, 1) != 0) ? 3'b001 : 3'b010;
                2:       b = ($urandom_range(0, 1) != 0) ? 3'b100 : 3'b011;
                default: b = ($urandom_range(0, 1) != 0) ? 3'b101 : 3'b110;
            endcase
            cw[3*k +: 3] = b;
        end
        return cw;
    endfunction

    task automatic run_word(input logic [26:0] cw, output logic [DWB-1:0] d,
                            output logic e, output int lat, output logic ready_low);
        check("ready_before_accept", 32'(code_ready), 32'd1);
        codein     = cw;
        code_valid = 1'b1;
        step();
        code_valid = 1'b0;
        ready_low  = 1'b1;
        lat        = 0;
        while (data_valid !== 1'b1 && lat < 40) begin
            if (code_ready !== 1'b0) ready_low = 1'b0;
            step();
            lat++;
        end
        if (code_ready !== 1'b0) ready_low = 1'b0;
        d = dataout;
        e = code_err;
    endtask

    task automatic word_and_check(input string tag, input logic [26:0] cw);
        logic [DWB-1:0] d;
        logic           e;
        int             lat;
        logic           rl;
        longint         s;
        s = model_sum(cw);
        run_word(cw, d, e, lat, rl);
        check({tag, "_latency"}, 32'(lat), 32'd9);
        check({tag, "_ready_low"}, 32'(rl), 32'd1);
        check({tag, "_dataout"}, 32'(d), 32'(s % FULL));
        check({tag, "_err"}, 32'(e), 32'(s >= FULL));
        step();
        check({tag, "_valid_drop"}, 32'(data_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(code_ready), 32'd1);
    endtask

    initial begin
        logic [DWB-1:0] d;
        logic [DWB-1:0] held;
        logic           e;
        int             lat;
        logic           rl;
        logic           seen_valid;
        int unsigned    v;
        logic [26:0]    cw;

        repeat (3) step();
        check("reset_code_ready", 32'(code_ready), 32'd1);
        check("reset_data_valid", 32'(data_valid), 32'd0);
        check("reset_dataout", 32'(dataout), 32'd0);
        check("reset_code_err", 32'(code_err), 32'd0);
        reset = 1'b0;
        step();

        word_and_check("zero", 27'h0);
        word_and_check("one", 27'h1);
        word_and_check("msb", 27'h1 << 26);
        word_and_check("top_group", 27'h7 << 24);
        word_and_check("all_ones", 27'h7FFFFFF);
        word_and_check("mid", 27'h2AAAAAA);

        run_word(27'h1 << 26, d, e, lat, rl);
        check("msb_abs", 32'(d), 32'd131072);
        step();
        run_word(27'h7FFFFFF, d, e, lat, rl);
        check("all_ones_err_abs", 32'(e), 32'd1);
        check("all_ones_valid", 32'(data_valid), 32'd1);
        step();

        for (int i = 0; i < 2500; i++) begin
            v  = $urandom_range(0, FULL - 1);
            cw = encode(v);
            run_word(cw, d, e, lat, rl);
            check("loop_dataout", 32'(d), 32'(v));
            check("loop_err", 32'(e), 32'd0);
            check("loop_latency", 32'(lat), 32'd9);
            step();
        end

        for (int i = 0; i < 150; i++) begin
            cw = 27'($urandom);
            word_and_check("raw", cw);
        end

        data_ready = 1'b0;
        cw = encode(32'd12345);
        run_word(cw, d, e, lat, rl);
        held = d;
        check("stall_first", 32'(d), 32'd12345);
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                codein     = encode(32'd777);
                code_valid = 1'b1;
            end
            step();
            check("stall_valid", 32'(data_valid), 32'd1);
            check("stall_dataout", 32'(dataout), 32'(held));
            check("stall_ready", 32'(code_ready), 32'd0);
        end
        code_valid = 1'b0;
        data_ready = 1'b1;
        step();
        check("stall_release_valid", 32'(data_valid), 32'd0);
        check("stall_release_ready", 32'(code_ready), 32'd1);
        word_and_check("after_stall", encode(32'd200000));

        codein     = encode(32'd5555);
        code_valid = 1'b1;
        step();
        code_valid = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_run_ready", 32'(code_ready), 32'd1);
        check("rst_run_valid", 32'(data_valid), 32'd0);
        seen_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (data_valid !== 1'b0) seen_valid = 1'b1;
        end
        check("rst_run_no_valid", 32'(seen_valid), 32'd0);
        word_and_check("after_reset", encode(32'd99999));

        reset      = 1'b1;
        code_valid = 1'b1;
        codein     = encode(32'd42);
        step();
        reset      = 1'b0;
        code_valid = 1'b0;
        check("rst_valid_ready", 32'(code_ready), 32'd1);
        seen_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (data_valid !== 1'b0) seen_valid = 1'b1;
        end
        check("rst_valid_no_accept", 32'(seen_valid), 32'd0);
        word_and_check("final", encode(32'd262143));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
